// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arbiter_pkg;

  // Width of the outstanding-request counter; holds up to 15 in flight.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

endpackage

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave pipelined Wishbone arbiter with round-robin grant
// between bus cycles and a bounded number of requests in flight.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no owner; slave idle, both masters stalled, guard for late acks
// GRANT0 | master 0 (instruction fetch) owns the slave
// GRANT1 | master 1 (data) owns the slave
module wb_arbiter2
  import wb_arbiter_pkg::*;
#(
  parameter int max_outstanding = 4
) (
  input  logic        clk,
  input  logic        rst,
  // master 0
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_adr,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic        m0_stall,
  // master 1
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_adr,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        m1_stall,
  // shared slave
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_adr,
  output logic [3:0]  s_sel,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_ack,
  input  logic        s_err,
  input  logic        s_stall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(max_outstanding);

  state_t           state, state_nxt;
  logic             last_grant, last_grant_nxt;
  logic [CNT_W-1:0] cnt;
  logic             granted, owner_cyc, full, abandon, accept, retire;

  assign granted   = (state == GRANT0) || (state == GRANT1);
  assign owner_cyc = (state == GRANT1) ? m1_cyc : m0_cyc;
  assign full      = (cnt == CNT_MAX);
  // Owner walked away with requests still in flight; their acks go nowhere.
  assign abandon   = granted && !owner_cyc && (cnt != '0);
  assign accept    = s_stb && !s_stall;
  assign retire    = s_ack || s_err;

  // Read data is shared; each master qualifies it with its own ack.
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

  // State register and round-robin history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Next state: grant only from IDLE, release as soon as the owner drops cyc.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (m0_cyc && (!m1_cyc || last_grant)) begin
          state_nxt      = GRANT0;
          last_grant_nxt = 1'b0;
        end else if (m1_cyc) begin
          state_nxt      = GRANT1;
          last_grant_nxt = 1'b1;
        end
      end
      GRANT0:  if (!m0_cyc) state_nxt = IDLE;
      GRANT1:  if (!m1_cyc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Forward muxes: owner drives the slave, the other master is held off.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_sel    = '0;
    s_wdata  = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_stall = 1'b1;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_stall = 1'b1;
    case (state)
      GRANT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_cyc && m0_stb && !full;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_sel    = m0_sel;
        s_wdata  = m0_wdata;
        m0_stall = s_stall || full;
        m0_ack   = s_ack && !abandon;
        m0_err   = s_err && !abandon;
      end
      GRANT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_cyc && m1_stb && !full;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_sel    = m1_sel;
        s_wdata  = m1_wdata;
        m1_stall = s_stall || full;
        m1_ack   = s_ack && !abandon;
        m1_err   = s_err && !abandon;
      end
      default: ;
    endcase
  end

  // Outstanding-request counter; saturates at zero on a stray retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (abandon) begin
      cnt <= '0;
    end else if (accept && !retire) begin
      cnt <= cnt + CNT_W'(1);
    end else if (retire && !accept && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // A retire while the owner has nothing outstanding is a slave protocol error.
  a_no_stray_retire : assert property (@(posedge clk) disable iff (rst)
    (granted && !abandon && retire) |-> (cnt != '0));

endmodule

// File: tb/tb_wb_arbiter2.sv
// Scoreboard bench for wb_arbiter2: requests push expected acks, a negedge
// monitor pops and compares master, data and arrival cycle.
module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [31:0] m0_adr = '0, m0_wdata = '0;
  logic [3:0]  m0_sel = '0;
  logic [31:0] m0_rdata;
  logic        m0_ack, m0_err, m0_stall;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m1_adr = '0, m1_wdata = '0;
  logic [3:0]  m1_sel = '0;
  logic [31:0] m1_rdata;
  logic        m1_ack, m1_err, m1_stall;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdata, s_rdata;
  logic [3:0]  s_sel;
  logic        s_ack, s_err, s_stall;

  wb_arbiter2 #(.max_outstanding(2)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_sel(m0_sel), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_stall(m0_stall),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_sel(m1_sel), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_stall(m1_stall),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_sel(s_sel), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .s_ack(s_ack), .s_err(s_err), .s_stall(s_stall)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int lat   = 1;
  int out_n = 0;
  int max_out = 0;

  typedef struct { int m; logic [31:0] data; int when; } exp_t;
  exp_t exp_q[$];

  // Instruction memory image: word i holds 0xA0 + i.
  logic [31:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 32'hA0 + 32'(i);

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Slave model: never stalls, acks each accepted request after lat cycles.
  logic [7:0]  ack_pipe;
  logic [31:0] dat_pipe [8];
  assign s_ack   = ack_pipe[0];
  assign s_rdata = dat_pipe[0];
  assign s_err   = 1'b0;
  assign s_stall = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_pipe <= '0;
    end else begin
      ack_pipe <= {1'b0, ack_pipe[7:1]};
      for (int i = 0; i < 7; i++) dat_pipe[i] <= dat_pipe[i+1];
      if (s_cyc && s_stb && !s_stall) begin
        ack_pipe[3'(lat-1)] <= 1'b1;
        dat_pipe[3'(lat-1)] <= mem[s_adr[5:2]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic logic stall_of(input int m);
    return (m == 0) ? m0_stall : m1_stall;
  endfunction

  task automatic mon_ack(input int m, input logic [31:0] d);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL spurious_ack: master %0d acked at cycle %0d, no ack expected", m, cyc_n);
    end else begin
      e = exp_q.pop_front();
      check("ack_master", 32'(m), 32'(e.m));
      check("ack_data", d, e.data);
      check("ack_cycle", 32'(cyc_n), 32'(e.when));
    end
  endtask

  // Monitor: compares every master ack against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      out_n = 0;
    end else begin
      if (m0_ack) mon_ack(0, m0_rdata);
      if (m1_ack) mon_ack(1, m1_rdata);
      if (m0_err || m1_err) check("no_err", {30'b0, m1_err, m0_err}, 32'h0);
      if (s_cyc && s_stb && !s_stall) out_n++;
      if (s_ack) out_n--;
      if (out_n > max_out) max_out = out_n;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request from master m; returns the number of stalled cycles.
  task automatic issue(input int m, input logic [31:0] adr, output int waits);
    waits = 0;
    if (m == 0) begin m0_stb = 1; m0_adr = adr; m0_sel = 4'hF; end
    else        begin m1_stb = 1; m1_adr = adr; m1_sel = 4'h3; end
    @(negedge clk);
    while (stall_of(m) && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 40) check("issue_timeout", 32'(stall_of(m)), 32'h0);
    check("s_stb_fwd", 32'(s_stb), 32'h1);
    check("s_adr_fwd", s_adr, adr);
    check("s_sel_fwd", 32'(s_sel), (m == 0) ? 32'hF : 32'h3);
    check("other_stalled", 32'(stall_of(1 - m)), 32'h1);
    exp_q.push_back('{m, mem[adr[5:2]], cyc_n + lat});
    tick();
    if (m == 0) m0_stb = 0; else m1_stb = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'h0);
    tick();
  endtask

  task automatic pulse_reset();
    rst = 1;
    exp_q.delete();
    tick();
    rst = 0;
  endtask

  task automatic abandon_case(input int l);
    int w;
    lat = l;
    m1_cyc = 1;
    issue(1, 32'h30, w);
    check("ab_m1_wait", 32'(w), 32'h1);
    m1_cyc = 0;
    m0_cyc = 1;
    exp_q.delete();
    @(negedge clk);
    check("ab_drop_m0_stall", 32'(m0_stall), 32'h1);
    @(negedge clk);
    check("ab_idle_m0_stall", 32'(m0_stall), 32'h1);
    check("ab_idle_no_ack", {30'b0, m1_ack, m0_ack}, 32'h0);
    @(negedge clk);
    check("ab_m0_granted", 32'(m0_stall), 32'h0);
    tick();
    issue(0, 32'h34, w);
    check("ab_m0_wait", 32'(w), 32'h0);
    drain();
    m0_cyc = 0;
    tick();
  endtask

  initial begin
    int w;
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_cyc", 32'(s_cyc), 32'h0);
    check("rst_s_stb", 32'(s_stb), 32'h0);
    check("rst_m0_stall", 32'(m0_stall), 32'h1);
    check("rst_m1_stall", 32'(m1_stall), 32'h1);
    rst = 0;

    // Single master, three back-to-back reads, 1-cycle slave
    lat = 1;
    m0_cyc = 1;
    issue(0, 32'h0, w); check("t1_wait0", 32'(w), 32'h1);
    issue(0, 32'h4, w); check("t1_wait1", 32'(w), 32'h0);
    issue(0, 32'h8, w); check("t1_wait2", 32'(w), 32'h0);
    tick();
    m0_cyc = 0;
    drain();

    // Contention from reset: m0 first, guard cycle, then m1, then back to m0
    pulse_reset();
    m0_cyc = 1;
    m1_cyc = 1;
    issue(0, 32'hC, w); check("t2_m0_wins", 32'(w), 32'h1);
    tick();
    m0_cyc = 0;
    @(negedge clk); check("t2_drop_m1_stall", 32'(m1_stall), 32'h1);
    @(negedge clk); check("t2_idle_m1_stall", 32'(m1_stall), 32'h1);
    @(negedge clk); check("t2_m1_granted", 32'(m1_stall), 32'h0);
    tick();
    issue(1, 32'h10, w); check("t2_m1_wait", 32'(w), 32'h0);
    m0_cyc = 1;
    @(negedge clk); check("t2_no_preempt", 32'(m0_stall), 32'h1);
    tick();
    m1_cyc = 0;
    @(negedge clk); check("t2_m1drop_m0_stall", 32'(m0_stall), 32'h1);
    @(negedge clk); check("t2_idle2_m0_stall", 32'(m0_stall), 32'h1);
    @(negedge clk); check("t2_m0_regranted", 32'(m0_stall), 32'h0);
    tick();
    issue(0, 32'h1C, w); check("t2_m0_wait", 32'(w), 32'h0);
    tick();
    m0_cyc = 0;
    tick();
    m0_cyc = 1;
    m1_cyc = 1;
    @(negedge clk); check("t2_rr_idle", 32'(m1_stall), 32'h1);
    @(negedge clk); check("t2_rr_m1_wins", 32'(m1_stall), 32'h0);
    check("t2_rr_m0_held", 32'(m0_stall), 32'h1);
    tick();
    m0_cyc = 0;
    m1_cyc = 0;
    drain();
    tick();

    // Outstanding limit of 2 with a 3-cycle slave
    lat = 3;
    max_out = 0;
    m0_cyc = 1;
    issue(0, 32'h20, w); check("t3_wait0", 32'(w), 32'h1);
    issue(0, 32'h24, w); check("t3_wait1", 32'(w), 32'h0);
    issue(0, 32'h28, w); check("t3_wait2_full", 32'(w), 32'h2);
    drain();
    check("t3_max_outstanding", 32'(max_out), 32'h2);
    m0_cyc = 0;
    tick();

    // Abandon with the ack landing in the abandon cycle, then in IDLE
    abandon_case(1);
    abandon_case(2);

    // Asynchronous reset mid-transfer with two requests in flight
    lat = 4;
    m0_cyc = 1;
    issue(0, 32'h38, w); check("t5_wait0", 32'(w), 32'h1);
    issue(0, 32'h3C, w); check("t5_wait1", 32'(w), 32'h0);
    #2;
    rst = 1;
    exp_q.delete();
    #1;
    check("t5_rst_s_cyc", 32'(s_cyc), 32'h0);
    check("t5_rst_s_stb", 32'(s_stb), 32'h0);
    check("t5_rst_m0_stall", 32'(m0_stall), 32'h1);
    check("t5_rst_m1_stall", 32'(m1_stall), 32'h1);
    tick();
    rst = 0;
    lat = 1;
    m1_cyc = 1;
    issue(0, 32'h14, w); check("t5_m0_priority", 32'(w), 32'h1);
    drain();
    m0_cyc = 0;
    m1_cyc = 0;
    repeat (3) tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
